seg7_scroll_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 62 ++++++
 rtl/seg7_scan_timer.sv | 53 +++++
 rtl/seg7_scroll_scan.sv | 89 ++++++++
 tb/tb_seg7_scroll_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment-pattern constants for the pattern sequencer and the display stage.
// Pattern layout: bit 7 = dp, bits 6:0 = g f e d c b a (segment a in bit 0).
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK  = 8'h00;
   localparam int         SEG_DP_BIT = 7;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_A     = 8'h77;
   localparam logic [7:0] SEG_B     = 8'h7C;
   localparam logic [7:0] SEG_C     = 8'h39;
   localparam logic [7:0] SEG_D     = 8'h5E;
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_F     = 8'h71;
   localparam logic [7:0] SEG_H     = 8'h76;
   localparam logic [7:0] SEG_L     = 8'h38;
   localparam logic [7:0] SEG_P     = 8'h73;
   localparam logic [7:0] SEG_U     = 8'h3E;
   localparam logic [7:0] SEG_MINUS = 8'h40;

   function automatic logic [7:0] with_dp(input logic [7:0] pat);
      logic [7:0] res;
      res             = pat;
      res[SEG_DP_BIT] = 1'b1;
      return res;
   endfunction

   function automatic logic [7:0] hex_to_seg(input logic [3:0] val);
      logic [7:0] res;
      res = SEG_BLANK;
      case (val)
         4'h0: res = SEG_0;
         4'h1: res = SEG_1;
         4'h2: res = SEG_2;
         4'h3: res = SEG_3;
         4'h4: res = SEG_4;
         4'h5: res = SEG_5;
         4'h6: res = SEG_6;
         4'h7: res = SEG_7;
         4'h8: res = SEG_8;
         4'h9: res = SEG_9;
         4'hA: res = SEG_A;
         4'hB: res = SEG_B;
         4'hC: res = SEG_C;
         4'hD: res = SEG_D;
         4'hE: res = SEG_E;
         4'hF: res = SEG_F;
         default: res = SEG_BLANK;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan/scroll timebase: digit slot counter, digit index, frame counter,
// plus the per-cycle lit decision (blank interval and brightness PWM).
module seg7_scan_timer #(
   parameter  int DIGITS       = 4,
   parameter  int SCAN_DIV     = 1024,
   parameter  int BLANK_CYCLES = 8,
   parameter  int SCROLL_DIV   = 64,
   localparam int DIG_W        = $clog2(DIGITS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       bright,
   output logic [DIG_W-1:0] dig_idx,
   output logic             lit,
   output logic             scroll_tick
);

   localparam int SCAN_W   = $clog2(SCAN_DIV);
   localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0]   BLANK_END   = SCAN_W'(BLANK_CYCLES);
   localparam logic [DIG_W-1:0]    DIG_LAST    = DIG_W'(DIGITS - 1);
   localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);

   logic [SCAN_W-1:0]   scan_cnt;
   logic [SCROLL_W-1:0] scroll_cnt;
   logic [3:0]          phase;
   logic                frame_end;

   // PWM phase is the top nibble so the duty steps scale with any SCAN_DIV.
   assign phase       = scan_cnt[SCAN_W-1 -: 4];
   assign frame_end   = (scan_cnt == SCAN_LAST) && (dig_idx == DIG_LAST);
   assign scroll_tick = frame_end && (scroll_cnt == SCROLL_LAST);
   assign lit         = (scan_cnt >= BLANK_END) && (phase < bright);

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt   <= '0;
         dig_idx    <= '0;
         scroll_cnt <= '0;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
         if (scan_cnt == SCAN_LAST) begin
            dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
         end
         if (frame_end) begin
            scroll_cnt <= (scroll_cnt == SCROLL_LAST) ? '0 : scroll_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scroll_scan.sv
// Scrolling multiplexed 7-segment driver: right-to-left pattern buffer fed at
// the scroll rate, scanned onto a shared segment bus with one-hot digit enables.
module seg7_scroll_scan #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1024,
   parameter int BLANK_CYCLES = 8,
   parameter int SCROLL_DIV   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        seg_in,
   input  logic              seg_valid,
   output logic              seg_ready,
   input  logic              clear,
   input  logic [3:0]        bright,
   output logic [7:0]        seg_out,
   output logic [DIGITS-1:0] dig_en
);

   import seg7_pkg::*;

   localparam int DIG_W = $clog2(DIGITS);

   logic [DIG_W-1:0]  dig_idx;
   logic              lit;
   logic              scroll_tick;
   logic              pending;
   logic              accept;
   logic [DIGITS-1:0] dig_onehot;
   logic [7:0]        disp_buf [DIGITS];

   seg7_scan_timer #(
      .DIGITS       (DIGITS),
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES),
      .SCROLL_DIV   (SCROLL_DIV)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .bright      (bright),
      .dig_idx     (dig_idx),
      .lit         (lit),
      .scroll_tick (scroll_tick)
   );

   // Handshake: a pattern transfers on any rising edge where seg_valid and
   // seg_ready are both high; seg_ready is high only while a scroll step is owed.
   assign seg_ready  = pending;
   assign accept     = seg_valid && pending;
   assign dig_onehot = DIGITS'(1) << dig_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            disp_buf[i] <= SEG_BLANK;
         end
         seg_out <= SEG_BLANK;
         dig_en  <= '0;
      end else begin
         // A tick landing on the accept cycle re-arms, so at most one step is owed.
         if (scroll_tick) begin
            pending <= 1'b1;
         end else if (accept) begin
            pending <= 1'b0;
         end

         if (clear) begin
            for (int i = 0; i < DIGITS; i++) begin
               disp_buf[i] <= SEG_BLANK;
            end
         end else if (accept) begin
            for (int i = 0; i < DIGITS - 1; i++) begin
               disp_buf[i] <= disp_buf[i+1];
            end
            disp_buf[DIGITS-1] <= seg_in;
         end

         if (lit) begin
            seg_out <= disp_buf[dig_idx];
            dig_en  <= dig_onehot;
         end else begin
            seg_out <= SEG_BLANK;
            dig_en  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scroll_scan.sv
// Directed bench for seg7_scroll_scan: expected per-cycle outputs are queued
// by the driver and checked by an independent negedge monitor.
module tb_seg7_scroll_scan;

   localparam int DIGITS       = 4;
   localparam int SCAN_DIV     = 16;
   localparam int BLANK_CYCLES = 2;
   localparam int SCROLL_DIV   = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seg_in;
   logic       seg_valid;
   logic       seg_ready;
   logic       clear;
   logic [3:0] bright;
   logic [7:0] seg_out;
   logic [3:0] dig_en;

   int applied     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // {seg_out, dig_en, seg_ready}
   logic [12:0] exp_q[$];
   int          cyc_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   // cyc = index of the DUT state cycle in progress (0 = first cycle after reset).
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   seg7_scroll_scan #(
      .DIGITS       (DIGITS),
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES),
      .SCROLL_DIV   (SCROLL_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .seg_valid (seg_valid),
      .seg_ready (seg_ready),
      .clear     (clear),
      .bright    (bright),
      .seg_out   (seg_out),
      .dig_en    (dig_en)
   );

   task automatic push_exp(input int at, input logic [7:0] seg, input logic [3:0] en,
                           input logic rdy, input string name);
      exp_q.push_back({seg, en, rdy});
      cyc_q.push_back(at);
      name_q.push_back(name);
   endtask

   // Outputs seen in cycle n come from the scan position of cycle n-1.
   task automatic push_span(input int from, input int upto, input int br,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int rdy_from, input string name);
      logic [7:0] bb [4];
      bb = '{b0, b1, b2, b3};
      for (int n = from; n <= upto; n++) begin
         int         s;
         int         scan;
         int         idx;
         logic       on;
         logic [7:0] seg;
         logic [3:0] en;
         s    = n - 1;
         scan = s % SCAN_DIV;
         idx  = (s / SCAN_DIV) % DIGITS;
         on   = (scan >= BLANK_CYCLES) && (scan < br);
         seg  = on ? bb[idx] : 8'h00;
         en   = on ? (4'b0001 << idx) : 4'b0000;
         push_exp(n, seg, en, (n >= rdy_from), name);
      end
   endtask

   // Monitor: one queued expectation per cycle, consumed when its cycle arrives.
   always @(negedge clk) begin
      if (cyc_q.size() > 0) begin
         if (cyc_q[0] == cyc) begin
            logic [12:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            void'(cyc_q.pop_front());
            applied++;
            if ({seg_out, dig_en, seg_ready} !== e) begin
               miscompares++;
               $display("FAIL %s cyc %0d: got seg=%h en=%b rdy=%b, want seg=%h en=%b rdy=%b",
                        nm, cyc, seg_out, dig_en, seg_ready, e[12:5], e[4:1], e[0]);
            end
         end else if (cyc_q[0] < cyc) begin
            applied++;
            miscompares++;
            $display("FAIL %s: expectation for cyc %0d missed at cyc %0d",
                     name_q[0], cyc_q[0], cyc);
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            void'(name_q.pop_front());
         end
      end
   end

   task automatic wait_cyc(input int target);
      for (int k = 0; k < 3000 && cyc != target; k++) @(negedge clk);
      if (cyc != target) begin
         applied++;
         miscompares++;
         $display("FAIL wait_cyc: got cyc %0d, want %0d", cyc, target);
      end
   endtask

   task automatic wait_ready(input int exp_cyc, input string name);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (seg_ready === 1'b1) break;
      end
      applied++;
      if (cyc != exp_cyc || seg_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s: seg_ready=%b at cyc %0d, want 1 at cyc %0d",
                  name, seg_ready, cyc, exp_cyc);
      end
   endtask

   initial begin
      rst       = 1'b1;
      seg_valid = 1'b1;
      seg_in    = 8'hFF;
      clear     = 1'b0;
      bright    = 4'd15;
      for (int i = 0; i < 3; i++) push_exp(0, 8'h00, 4'b0000, 1'b0, "reset_hold");
      repeat (3) @(negedge clk);
      rst       = 1'b0;
      seg_valid = 1'b0;
      seg_in    = 8'h00;
      push_span(1, 128, 15, 8'h00, 8'h00, 8'h00, 8'h00, 128, "scan_idle");

      wait_ready(128, "first_ready");
      seg_valid = 1'b1;
      seg_in    = 8'h5B;
      push_span(129, 256, 15, 8'h00, 8'h00, 8'h00, 8'h5B, 256, "scroll_5b");
      @(negedge clk);
      seg_valid = 1'b0;

      wait_ready(256, "second_ready");
      seg_valid = 1'b1;
      seg_in    = 8'h4F;
      push_span(257, 768, 15, 8'h00, 8'h00, 8'h5B, 8'h4F, 384, "backpressure");
      @(negedge clk);
      seg_valid = 1'b0;

      wait_cyc(768);
      seg_valid = 1'b1;
      seg_in    = 8'h06;
      push_span(769, 1023, 15, 8'h00, 8'h5B, 8'h4F, 8'h06, 896, "accept_drop");
      @(negedge clk);
      seg_valid = 1'b0;

      // Accept on the tick cycle itself: ready must stay high.
      wait_cyc(1023);
      seg_valid = 1'b1;
      seg_in    = 8'h6D;
      push_span(1024, 1088, 15, 8'h5B, 8'h4F, 8'h06, 8'h6D, 0, "tick_rearm");
      @(negedge clk);
      seg_valid = 1'b0;

      wait_cyc(1088);
      bright = 4'd0;
      push_span(1089, 1152, 0, 8'h5B, 8'h4F, 8'h06, 8'h6D, 0, "bright0");

      wait_cyc(1152);
      bright = 4'd8;
      push_span(1153, 1216, 8, 8'h5B, 8'h4F, 8'h06, 8'h6D, 0, "bright8");

      wait_cyc(1216);
      clear     = 1'b1;
      seg_valid = 1'b1;
      seg_in    = 8'h3E;
      push_span(1217, 1270, 8, 8'h00, 8'h00, 8'h00, 8'h00, 1 << 30, "clear_collide");
      @(negedge clk);
      clear     = 1'b0;
      seg_valid = 1'b0;

      wait_cyc(1270);
      rst = 1'b1;
      push_exp(0, 8'h00, 4'b0000, 1'b0, "mid_reset");
      @(negedge clk);
      rst = 1'b0;

      repeat (4) @(negedge clk);
      applied++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d unconsumed expectations, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
